// File: rtl/horner_pkg.sv
// Shared types and default sizing for the Horner polynomial evaluator.
package horner_pkg;

  localparam int DEF_W       = 32;
  localparam int DEF_DEG_MAX = 15;
  localparam int DEF_IDX_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    INIT,
    MUL,
    ADD,
    DONE
  } state_t;

endpackage

// File: rtl/horner_mac_stage.sv
// Multiply/add register stage: prod = acc*x on mul_en, then acc = prod + c on add_en.
module horner_mac_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic         mul_en,
  input  logic         add_en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] c,
  output logic [W-1:0] acc
);

  logic [W-1:0] prod;

  // Products and sums wrap to W bits; there is no carry or overflow output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en) begin
        prod <= acc * x;
      end
      if (load_en) begin
        acc <= c;
      end else if (add_en) begin
        acc <= prod + c;
      end
    end
  end

endmodule

// File: rtl/horner_seq_ctrl.sv
// Horner-rule sequencer: fetches coefficients from a synchronous-read RAM and drives
// one shared mul/add stage to evaluate p(x) one iteration every two cycles.
module horner_seq_ctrl
  import horner_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEG_MAX = DEF_DEG_MAX,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     x_in,
  input  logic [IDX_W-1:0] deg,
  output logic             coef_rd_en,
  output logic [IDX_W-1:0] coef_idx,
  input  logic [W-1:0]     coef_data,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result
);

  state_t state, next_state;

  logic [W-1:0]     x_q;
  logic [W-1:0]     acc;
  logic [W-1:0]     result_q;
  logic [IDX_W-1:0] deg_q;
  logic [IDX_W-1:0] deg_clamped;
  logic             load_en;
  logic             mul_en;
  logic             add_en;

  // Clamping is only needed when the index field can encode degrees above DEG_MAX.
  if (DEG_MAX < (2 ** IDX_W) - 1) begin : g_clamp
    always_comb begin
      deg_clamped = (int'(deg) > DEG_MAX) ? IDX_W'(DEG_MAX) : deg;
    end
  end else begin : g_no_clamp
    assign deg_clamped = deg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   next_state = INIT;
      INIT:    next_state = (deg_q == '0) ? DONE : MUL;
      MUL:     next_state = ADD;
      ADD:     next_state = (coef_idx == '0) ? DONE : MUL;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    coef_rd_en = (state == FETCH) || (state == MUL);
    load_en    = (state == INIT);
    mul_en     = (state == MUL);
    add_en     = (state == ADD);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  // coef_idx is set one cycle ahead of each read so the RAM sees a stable address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      deg_q    <= '0;
      coef_idx <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q      <= x_in;
            deg_q    <= deg_clamped;
            coef_idx <= deg_clamped;
          end
        end
        INIT: begin
          if (deg_q != '0) begin
            coef_idx <= deg_q - IDX_W'(1);
          end
        end
        ADD: begin
          if (coef_idx != '0) begin
            coef_idx <= coef_idx - IDX_W'(1);
          end
        end
        DONE:    result_q <= acc;
        default: ;
      endcase
    end
  end

  // The final sum is forwarded during DONE so result is valid alongside the done pulse.
  assign result = (state == DONE) ? acc : result_q;

  horner_mac_stage #(
    .W(W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .mul_en  (mul_en),
    .add_en  (add_en),
    .x       (x_q),
    .c       (coef_data),
    .acc     (acc)
  );

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// Directed bench for horner_seq_ctrl with a synchronous-read coefficient RAM model.
module tb_horner_seq_ctrl;

  localparam int W     = 32;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     x_in = '0;
  logic [IDX_W-1:0] deg = '0;
  logic             coef_rd_en;
  logic [IDX_W-1:0] coef_idx;
  logic [W-1:0]     coef_data = '0;
  logic             busy;
  logic             done;
  logic [W-1:0]     result;

  logic [W-1:0] mem [16];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]         deg;
    logic [W-1:0]       x;
    logic [15:0][W-1:0] coefs;
    logic [W-1:0]       exp_result;
    logic [7:0]         exp_done;
    logic [31:0]        restart_mask;
  } vec_t;

  vec_t vecs [6];

  horner_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .deg        (deg),
    .coef_rd_en (coef_rd_en),
    .coef_idx   (coef_idx),
    .coef_data  (coef_data),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (coef_rd_en) coef_data <= mem[coef_idx];
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int id);
    int             done_cycle;
    logic [W-1:0]   res;
    logic           post_done;
    logic           post_busy;
    logic [W-1:0]   post_res;
    int             bad_rd;
    int             idx_err;
    logic [IDX_W-1:0] rd_idx [$];

    for (int i = 0; i < 16; i++) mem[i] = v.coefs[i];
    done_cycle = -1;
    res = '0;
    post_done = 1'b1;
    post_busy = 1'b1;
    post_res = '0;
    bad_rd = 0;
    idx_err = 0;

    @(negedge clk);
    check_output($sformatf("v%0d_idle_busy", id), 64'(busy), 64'd0);
    x_in  = v.x;
    deg   = v.deg;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = 32'hDEAD_BEEF;
    deg   = v.deg + 4'd5;

    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k < 32) ? v.restart_mask[k] : 1'b0;
      if (coef_rd_en) begin
        rd_idx.push_back(coef_idx);
        if (!busy || done) bad_rd++;
      end
      if (done_cycle >= 0) begin
        post_done = done;
        post_busy = busy;
        post_res  = result;
        break;
      end
      if (done) begin
        done_cycle = k;
        res = result;
      end
    end
    start = 1'b0;

    check_output($sformatf("v%0d_done_cycle", id), 64'(done_cycle), 64'(v.exp_done));
    check_output($sformatf("v%0d_result", id), 64'(res), 64'(v.exp_result));
    check_output($sformatf("v%0d_done_pulse", id), 64'(post_done), 64'd0);
    check_output($sformatf("v%0d_busy_after", id), 64'(post_busy), 64'd0);
    check_output($sformatf("v%0d_result_held", id), 64'(post_res), 64'(v.exp_result));
    check_output($sformatf("v%0d_rd_count", id), 64'(rd_idx.size()), 64'(int'(v.deg) + 1));
    for (int j = 0; j < rd_idx.size(); j++) begin
      if (int'(rd_idx[j]) != int'(v.deg) - j) idx_err++;
    end
    check_output($sformatf("v%0d_idx_seq", id), 64'(idx_err), 64'd0);
    check_output($sformatf("v%0d_rd_outside", id), 64'(bad_rd), 64'd0);
  endtask

  initial begin
    vecs[0] = '0;
    vecs[0].deg = 4'd0;  vecs[0].x = 32'd9;
    vecs[0].coefs[0] = 32'd7;
    vecs[0].exp_result = 32'd7;  vecs[0].exp_done = 8'd3;

    vecs[1] = '0;
    vecs[1].deg = 4'd2;  vecs[1].x = 32'd3;
    vecs[1].coefs[2] = 32'd2;  vecs[1].coefs[1] = 32'd5;  vecs[1].coefs[0] = 32'd1;
    vecs[1].exp_result = 32'd34;  vecs[1].exp_done = 8'd7;

    vecs[2] = '0;
    vecs[2].deg = 4'd1;  vecs[2].x = 32'hFFFF_FFFF;
    vecs[2].coefs[1] = 32'd2;  vecs[2].coefs[0] = 32'd3;
    vecs[2].exp_result = 32'h0000_0001;  vecs[2].exp_done = 8'd5;

    vecs[3] = '0;
    vecs[3].deg = 4'd3;  vecs[3].x = 32'd2;
    vecs[3].coefs[3] = 32'd1;  vecs[3].coefs[2] = 32'd2;
    vecs[3].coefs[1] = 32'd3;  vecs[3].coefs[0] = 32'd4;
    vecs[3].exp_result = 32'd26;  vecs[3].exp_done = 8'd9;
    vecs[3].restart_mask = 32'h0000_0084;

    vecs[4] = '0;
    vecs[4].deg = 4'd4;  vecs[4].x = 32'd10;
    vecs[4].coefs[4] = 32'd1;  vecs[4].coefs[3] = 32'd2;  vecs[4].coefs[2] = 32'd3;
    vecs[4].coefs[1] = 32'd4;  vecs[4].coefs[0] = 32'd5;
    vecs[4].exp_result = 32'd12345;  vecs[4].exp_done = 8'd11;

    vecs[5] = '0;
    vecs[5].deg = 4'd15;  vecs[5].x = 32'd1;
    for (int i = 0; i < 16; i++) vecs[5].coefs[i] = 32'd1;
    vecs[5].exp_result = 32'd16;  vecs[5].exp_done = 8'd33;

    for (int i = 0; i < 16; i++) mem[i] = '0;

    #1 reset = 1'b0;
    #1;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_rd_en", 64'(coef_rd_en), 64'd0);
    check_output("rst_idx", 64'(coef_idx), 64'd0);
    check_output("rst_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 6; v++) apply_stimulus(vecs[v], v);

    // Abort a deg=2 run in cycle 4, then rerun it cleanly.
    for (int i = 0; i < 16; i++) mem[i] = vecs[1].coefs[i];
    @(negedge clk);
    x_in  = vecs[1].x;
    deg   = vecs[1].deg;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_result", 64'(result), 64'd0);
    check_output("abort_idx", 64'(coef_idx), 64'd0);
    check_output("abort_rd_en", 64'(coef_rd_en), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(vecs[1], 6);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
